sram_arbiter: RTL and testbench

- Sequences and shares the 64x8 dffram macro between the Wishbone slave port and one design-side port (qcpu or mc14500 class designs).
- Sits between the multiplexer's Wishbone decode and the dffram instance.
- Replaces static select-based muxing with granted, handshaked single-byte accesses.
- Includes a starvation guard so Wishbone debug access stays possible while a design is running.

---
 rtl/sram_arbiter_if.sv | 45 ++++
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the Wishbone decode, the selected design and the
// dffram macro. The arbiter sits on the slave modport. The master modport
// is the surrounding environment: Wishbone master, design and SRAM macro.
interface sram_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              wbs_cyc_i;
   logic              wbs_stb_i;
   logic              wbs_we_i;
   logic [31:0]       wbs_adr_i;
   logic [31:0]       wbs_dat_i;
   logic [31:0]       wbs_dat_o;
   logic              wbs_ack_o;
   logic              dsn_en;
   logic              dsn_req;
   logic              dsn_we;
   logic [ADDR_W-1:0] dsn_addr;
   logic [DATA_W-1:0] dsn_wdata;
   logic [DATA_W-1:0] dsn_rdata;
   logic              dsn_ack;
   logic              sram_cen;
   logic              sram_gwen;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o,
      input  dsn_en, dsn_req, dsn_we, dsn_addr, dsn_wdata,
      output dsn_rdata, dsn_ack,
      output sram_cen, sram_gwen, sram_a, sram_d,
      input  sram_q
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o,
      output dsn_en, dsn_req, dsn_we, dsn_addr, dsn_wdata,
      input  dsn_rdata, dsn_ack,
      input  sram_cen, sram_gwen, sram_a, sram_d,
      output sram_q
   );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the 64x8 dffram between Wishbone and one design port.
// Every access is IDLE(grant) -> ACCESS(SRAM enabled) -> RESP(ack) -> GAP.
// Handshake: a requester holds its request (cyc&stb&sel, or req&en) until it
// sees its ack, which is high for exactly one cycle (RESP); requests are only
// sampled in IDLE, and address/data/we are latched at the grant edge.
// A starvation counter forces Wishbone through after STARVE_LIMIT design
// grants made while Wishbone was waiting.
module sram_arbiter #(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 4,
   parameter int WB_SEL_BIT   = 16
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n,
   sram_arbiter_if.slave bus,
   output logic [1:0]    grant,
   output logic [1:0]    dbg_state,
   output logic [7:0]    dbg_starve_cnt
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [1:0] GR_NONE = 2'b00;
   localparam logic [1:0] GR_WB   = 2'b01;
   localparam logic [1:0] GR_DSN  = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, GAP} state_t;

   state_t            state, next_state;
   logic [1:0]        owner;
   logic              we_q;
   logic [CNT_W-1:0]  starve_cnt;
   logic [DATA_W-1:0] wb_rd_hold;
   logic [DATA_W-1:0] dsn_rd_hold;
   logic              wb_req, d_req;
   logic              win_wb, win_dsn;
   logic              rd_resp;
   logic              unused_bits;

   assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i & bus.wbs_adr_i[WB_SEL_BIT];
   assign d_req  = bus.dsn_req & bus.dsn_en;

   // Only a handful of Wishbone address/data bits are decoded here.
   assign unused_bits = ^{bus.wbs_adr_i, bus.wbs_dat_i};

   // State register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) state <= IDLE;
      else           state <= next_state;
   end

   // Next state and winner selection; design wins ties unless starved-out.
   always_comb begin
      next_state = state;
      win_wb     = 1'b0;
      win_dsn    = 1'b0;
      case (state)
         IDLE: begin
            if (wb_req && d_req) begin
               if (starve_cnt == CNT_W'(STARVE_LIMIT)) win_wb  = 1'b1;
               else                                    win_dsn = 1'b1;
            end else if (wb_req) begin
               win_wb = 1'b1;
            end else if (d_req) begin
               win_dsn = 1'b1;
            end
            if (win_wb || win_dsn) next_state = ACCESS;
         end
         ACCESS:  next_state = RESP;
         RESP:    next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Grant latching, registered SRAM drive, starvation count and read holds.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         owner       <= GR_NONE;
         we_q        <= 1'b0;
         starve_cnt  <= '0;
         bus.sram_cen  <= 1'b1;
         bus.sram_gwen <= 1'b1;
         bus.sram_a    <= '0;
         bus.sram_d    <= '0;
         wb_rd_hold  <= '0;
         dsn_rd_hold <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_wb) begin
                  owner         <= GR_WB;
                  we_q          <= bus.wbs_we_i;
                  bus.sram_cen  <= 1'b0;
                  bus.sram_gwen <= ~bus.wbs_we_i;
                  bus.sram_a    <= bus.wbs_adr_i[ADDR_W+1:2];
                  bus.sram_d    <= bus.wbs_dat_i[DATA_W-1:0];
                  starve_cnt    <= '0;
               end else if (win_dsn) begin
                  owner         <= GR_DSN;
                  we_q          <= bus.dsn_we;
                  bus.sram_cen  <= 1'b0;
                  bus.sram_gwen <= ~bus.dsn_we;
                  bus.sram_a    <= bus.dsn_addr;
                  bus.sram_d    <= bus.dsn_wdata;
                  if (wb_req && starve_cnt != CNT_W'(STARVE_LIMIT))
                     starve_cnt <= starve_cnt + CNT_W'(1);
               end
            end
            ACCESS: begin
               bus.sram_cen  <= 1'b1;
               bus.sram_gwen <= 1'b1;
            end
            RESP: begin
               owner <= GR_NONE;
               if (!we_q && owner == GR_WB)  wb_rd_hold  <= bus.sram_q;
               if (!we_q && owner == GR_DSN) dsn_rd_hold <= bus.sram_q;
            end
            default: ;
         endcase
      end
   end

   // sram_q is valid during RESP, so read data bypasses the hold register then.
   assign rd_resp       = (state == RESP) && !we_q;
   assign bus.wbs_ack_o = (state == RESP) && (owner == GR_WB);
   assign bus.dsn_ack   = (state == RESP) && (owner == GR_DSN);
   assign bus.wbs_dat_o = (rd_resp && owner == GR_WB)
                          ? {{(32-DATA_W){1'b0}}, bus.sram_q}
                          : {{(32-DATA_W){1'b0}}, wb_rd_hold};
   assign bus.dsn_rdata = (rd_resp && owner == GR_DSN) ? bus.sram_q : dsn_rd_hold;
   assign grant          = owner;
   assign dbg_state      = state;
   assign dbg_starve_cnt = 8'(starve_cnt);
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural dffram model.
module tb_sram_arbiter;
   logic       clk;
   logic       rst_n;
   logic [1:0] grant;
   logic [1:0] dbg_state;
   logic [7:0] dbg_starve_cnt;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] mem [0:63];
   logic [1:0] exp_grant_q[$];
   logic [7:0] exp_cnt_q[$];

   sram_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

   sram_arbiter dut (
      .wb_clk_i       (clk),
      .wb_rst_n       (rst_n),
      .bus            (bus),
      .grant          (grant),
      .dbg_state      (dbg_state),
      .dbg_starve_cnt (dbg_starve_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dffram model: Q updates one clock after an enabled edge
   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_gwen) mem[bus.sram_a] <= bus.sram_d;
         bus.sram_q <= mem[bus.sram_a];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Wishbone single access; lat counts negedges from request to ack.
   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output logic [31:0] rd, output int lat, output int cens);
      logic got;
      got  = 1'b0;
      lat  = 0;
      cens = 0;
      rd   = '0;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      while (!got && lat < 40) begin
         tick();
         lat++;
         if (!bus.sram_cen) cens++;
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            rd  = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
      repeat (2) tick();
   endtask

   // Design single access; acks counts ack cycles including two trailing cycles.
   task automatic dsn_access(input logic we, input logic [5:0] addr, input logic [7:0] wdata,
                             output logic [7:0] rd, output int lat, output int cens, output int acks);
      logic got;
      got  = 1'b0;
      lat  = 0;
      cens = 0;
      acks = 0;
      rd   = '0;
      bus.dsn_req   = 1'b1;
      bus.dsn_we    = we;
      bus.dsn_addr  = addr;
      bus.dsn_wdata = wdata;
      while (!got && lat < 40) begin
         tick();
         lat++;
         if (!bus.sram_cen) cens++;
         if (bus.dsn_ack) begin
            got  = 1'b1;
            acks++;
            rd   = bus.dsn_rdata;
         end
      end
      bus.dsn_req = 1'b0;
      bus.dsn_we  = 1'b0;
      if (!got) check("dsn_ack_timeout", 32'd0, 32'd1);
      repeat (2) begin
         tick();
         if (bus.dsn_ack) acks++;
         if (!bus.sram_cen) cens++;
      end
   endtask

   initial begin
      logic [31:0] rd32;
      logic [7:0]  rd8;
      int          lat, cens, acks, cnt, seen, wb_t, dsn_t;
      logic [1:0]  prev;

      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      rst_n = 1'b0;
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
      bus.dsn_en = 0; bus.dsn_req = 0; bus.dsn_we = 0;
      bus.dsn_addr = 0; bus.dsn_wdata = 0;

      // reset values
      repeat (3) tick();
      check("rst_cen",   bus.sram_cen, 1);
      check("rst_gwen",  bus.sram_gwen, 1);
      check("rst_a",     bus.sram_a, 0);
      check("rst_d",     bus.sram_d, 0);
      check("rst_wback", bus.wbs_ack_o, 0);
      check("rst_wbdat", bus.wbs_dat_o, 0);
      check("rst_dack",  bus.dsn_ack, 0);
      check("rst_drd",   bus.dsn_rdata, 0);
      check("rst_grant", grant, 0);
      check("rst_state", dbg_state, 0);
      check("rst_cnt",   dbg_starve_cnt, 0);
      rst_n = 1'b1;
      tick();

      // WB write 0x5A to byte 5, then read back; ack in the third cycle counting the grant cycle
      wb_access(1'b1, 32'h0001_0014, 32'h0000_005A, rd32, lat, cens);
      check("wb_wr_lat", lat, 2);
      check("wb_wr_cen", cens, 1);
      wb_access(1'b0, 32'h0001_0014, 32'h0, rd32, lat, cens);
      check("wb_rd_lat", lat, 2);
      check("wb_rd_data", rd32, 32'h0000_005A);
      check("wb_rd_hold", bus.wbs_dat_o, 32'h0000_005A);

      // WB cycle outside the SRAM window is never acked
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = 32'h0000_0014;
      cnt = 0;
      repeat (8) begin
         tick();
         if (bus.wbs_ack_o || grant != 2'b00) cnt++;
      end
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      check("wb_nosel", cnt, 0);

      // design write 0xC3 to 63, then read it back
      bus.dsn_en = 1'b1;
      dsn_access(1'b1, 6'd63, 8'hC3, rd8, lat, cens, acks);
      check("dsn_wr_lat", lat, 2);
      check("dsn_wr_cen", cens, 1);
      check("dsn_wr_acks", acks, 1);
      check("dsn_wr_rdata", bus.dsn_rdata, 0);
      dsn_access(1'b0, 6'd63, 8'h00, rd8, lat, cens, acks);
      check("dsn_rd_data", rd8, 8'hC3);
      check("dsn_rd_cen", cens, 1);
      check("dsn_rd_acks", acks, 1);
      check("dsn_rd_hold", bus.dsn_rdata, 8'hC3);
      check("wb_hold_kept", bus.wbs_dat_o, 32'h0000_005A);

      // simultaneous requests with starve_cnt=0: design first, WB right after
      bus.dsn_req = 1; bus.dsn_we = 0; bus.dsn_addr = 6'd63;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h0001_0014;
      wb_t = 0; dsn_t = 0; rd32 = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (t == 1) begin
            check("tie_grant", grant, 2'b10);
            check("tie_cnt", dbg_starve_cnt, 1);
         end
         if (bus.dsn_ack && dsn_t == 0) begin dsn_t = t; bus.dsn_req = 0; end
         if (bus.wbs_ack_o && wb_t == 0) begin
            wb_t = t; rd32 = bus.wbs_dat_o;
            bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
         end
      end
      check("tie_dsn_t", dsn_t, 2);
      check("tie_wb_t", wb_t, 6);
      check("tie_wb_data", rd32, 32'h5A);
      check("tie_cnt_clr", dbg_starve_cnt, 0);

      // design holds its request with WB pending: four design grants, then WB
      exp_grant_q = {2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
      exp_cnt_q   = {8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
      bus.dsn_req = 1; bus.dsn_we = 0; bus.dsn_addr = 6'd63;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h0001_0014;
      prev = 2'b00; seen = 0;
      for (int t = 0; t < 60 && seen < 6; t++) begin
         tick();
         if (bus.wbs_ack_o) begin
            check("starve_wb_data", bus.wbs_dat_o, 32'h5A);
            bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
         end
         if (grant != 2'b00 && prev == 2'b00) begin
            check($sformatf("starve_grant%0d", seen), grant, exp_grant_q.pop_front());
            check($sformatf("starve_cnt%0d", seen), dbg_starve_cnt, exp_cnt_q.pop_front());
            seen++;
         end
         prev = grant;
      end
      check("starve_seen", seen, 6);
      bus.dsn_req = 0; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      repeat (4) tick();
      check("starve_cnt_end", dbg_starve_cnt, 0);

      // dsn_en low: design request ignored, WB proceeds
      bus.dsn_en = 0; bus.dsn_req = 1; bus.dsn_we = 1; bus.dsn_addr = 6'd9; bus.dsn_wdata = 8'h99;
      cnt = 0;
      repeat (8) begin
         tick();
         if (bus.dsn_ack || grant != 2'b00) cnt++;
      end
      check("dis_no_grant", cnt, 0);
      wb_access(1'b1, 32'h0001_0024, 32'h77, rd32, lat, cens);
      check("dis_wb_lat", lat, 2);
      bus.dsn_req = 0;

      // dsn_en drops during the design ACCESS cycle: access still completes
      bus.dsn_en = 1; bus.dsn_req = 1; bus.dsn_we = 1; bus.dsn_addr = 6'd9; bus.dsn_wdata = 8'h11;
      tick();
      check("drop_grant", grant, 2'b10);
      bus.dsn_en = 0; bus.dsn_req = 0;
      tick();
      check("drop_ack", bus.dsn_ack, 1);
      repeat (2) tick();
      wb_access(1'b0, 32'h0001_0024, 32'h0, rd32, lat, cens);
      check("drop_data", rd32, 32'h11);

      // reset during ACCESS of a WB write aborts it
      wb_t = 0;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
      bus.wbs_adr_i = 32'h0001_0030; bus.wbs_dat_i = 32'hEE;
      tick();
      check("abort_cen_lo", bus.sram_cen, 0);
      rst_n = 1'b0;
      #1;
      check("abort_cen_hi", bus.sram_cen, 1);
      check("abort_ack", bus.wbs_ack_o, 0);
      check("abort_state", dbg_state, 0);
      check("abort_wbdat", bus.wbs_dat_o, 0);
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      tick();
      if (bus.wbs_ack_o) wb_t++;
      rst_n = 1'b1;
      tick();
      if (bus.wbs_ack_o) wb_t++;
      check("abort_no_ack", wb_t, 0);
      check("abort_idle", dbg_state, 0);
      wb_access(1'b0, 32'h0001_0030, 32'h0, rd32, lat, cens);
      check("abort_not_written", rd32, 32'h0);
      wb_access(1'b0, 32'h0001_0014, 32'h0, rd32, lat, cens);
      check("abort_mem_kept", rd32, 32'h5A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
